// File: rtl/pipeline_hazard_ctrl_pkg.sv
// pipe_ctrl_pkg: shared state encoding, zero-register constant and dependency test
// for the pipeline hazard controller.
package pipe_ctrl_pkg;

    typedef enum logic {RUN, MEM_WAIT} state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // $zero never carries a real dependency, so it never matches.
    function automatic logic hazard_match(input logic [4:0] dest, input logic [4:0] src, input logic uses);
        return uses && dest != REG_ZERO && dest == src;
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// sat_counter: up-counter with synchronous clear that holds at LIMIT; async active-high reset.
module sat_counter #(
    parameter int W = 8,
    parameter logic [W-1:0] LIMIT = '1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc_i,
    input  logic         clr_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb cnt_d = clr_i ? '0 : (inc_i && cnt_q != LIMIT) ? cnt_q + 1'b1 : cnt_q;

    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush sequencer for the 5-stage pipeline.
// Define FORWARDING_EN when the datapath forwards, so only load-use hazards stall.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int WAIT_MAX = 255,
    parameter int CNT_W    = 16
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [4:0]       ID_Rs,
    input  logic [4:0]       ID_Rt,
    input  logic             ID_UsesRt,
    input  logic             EX_MemRead,
    input  logic             EX_RegWrite,
    input  logic [4:0]       EX_WriteReg,
    input  logic             MEM_RegWrite,
    input  logic [4:0]       MEM_WriteReg,
    input  logic             MEM_MemRead,
    input  logic             MEM_MemWrite,
    input  logic             MEM_Branch,
    input  logic             MEM_Zero,
    input  logic             MEM_Jump,
    input  logic             DMem_Ready,
    output logic             PC_Ld,
    output logic             IF_ID_Ld,
    output logic             ID_EX_Ld,
    output logic             EX_MEM_Ld,
    output logic             MEM_WB_Ld,
    output logic             IF_ID_Flush,
    output logic             ID_EX_Flush,
    output logic             EX_MEM_Flush,
    output logic             PCSrc,
    output logic             Stalled,
    output logic             Timeout,
    output logic [CNT_W-1:0] StallCount
);

    localparam int WW = $clog2(WAIT_MAX + 1);

    state_e        state_q;
    logic          timeout_q;
    logic [WW-1:0] wait_cnt;
    logic          taken, dep_ex, dep_mem, hazard, mem_stall, at_max;

    assign taken   = (MEM_Branch & MEM_Zero) | MEM_Jump;
    assign dep_ex  = hazard_match(EX_WriteReg, ID_Rs, 1'b1) | hazard_match(EX_WriteReg, ID_Rt, ID_UsesRt);
    assign dep_mem = hazard_match(MEM_WriteReg, ID_Rs, 1'b1) | hazard_match(MEM_WriteReg, ID_Rt, ID_UsesRt);
`ifdef FORWARDING_EN
    assign hazard  = EX_MemRead & dep_ex;
`else
    assign hazard  = ((EX_MemRead | EX_RegWrite) & dep_ex) | (MEM_RegWrite & dep_mem);
`endif
    // While waiting, the MEM controls are frozen, so readiness alone ends the wait.
    assign mem_stall = !DMem_Ready & ((MEM_MemRead | MEM_MemWrite) | state_q == MEM_WAIT);
    assign at_max    = wait_cnt == WW'(WAIT_MAX);

    always_comb begin
        PC_Ld        = !Rst & !mem_stall & (taken | !hazard);
        IF_ID_Ld     = PC_Ld;
        ID_EX_Ld     = !Rst & !mem_stall;
        EX_MEM_Ld    = ID_EX_Ld;
        MEM_WB_Ld    = ID_EX_Ld;
        IF_ID_Flush  = Rst | (!mem_stall & taken);
        ID_EX_Flush  = Rst | (!mem_stall & (taken | hazard));
        EX_MEM_Flush = IF_ID_Flush;
        PCSrc        = !Rst & !mem_stall & taken;
        Stalled      = !Rst & (mem_stall | (!taken & hazard));
        Timeout      = timeout_q | at_max;
    end

    always_ff @(posedge Clk or posedge Rst)
        if (Rst) begin
            state_q   <= RUN;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= mem_stall ? MEM_WAIT : RUN;
            timeout_q <= timeout_q | at_max;
        end

    sat_counter #(.W(WW), .LIMIT(WW'(WAIT_MAX))) u_wait (
        .clk_i(Clk), .rst_i(Rst), .inc_i(mem_stall), .clr_i(!mem_stall), .cnt_o(wait_cnt)
    );

    sat_counter #(.W(CNT_W), .LIMIT({CNT_W{1'b1}})) u_stall (
        .clk_i(Clk), .rst_i(Rst), .inc_i(Stalled), .clr_i(1'b0), .cnt_o(StallCount)
    );

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline.
- Drives the Ld and Flush inputs of the PC and of the IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Resolves load-use hazards, branches/jumps resolved in MEM, and multi-cycle data-memory accesses.
- Small FSM plus wait-timeout and stall-statistics counters.

Parameters:
- WAIT_MAX, 255: maximum DMem wait cycles before Timeout is raised.
- CNT_W, 16: width of the StallCount performance counter.

Ports:
- Clk  in  1  clock
- Rst  in  1  asynchronous active-high reset
- ID_Rs, ID_Rt  in  5  source registers of the instruction in ID
- ID_UsesRt  in  1  ID instruction reads Rt
- EX_MemRead, EX_RegWrite  in  1  EX-stage controls
- EX_WriteReg  in  5  EX destination register
- MEM_RegWrite  in  1  MEM-stage control
- MEM_WriteReg  in  5  MEM destination register
- MEM_MemRead, MEM_MemWrite, MEM_Branch, MEM_Zero, MEM_Jump  in  1  MEM-stage controls
- DMem_Ready  in  1  data memory completes the access this cycle
- PC_Ld, IF_ID_Ld, ID_EX_Ld, EX_MEM_Ld, MEM_WB_Ld  out  1  register load enables
- IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush  out  1  synchronous clear request; has priority over Ld at the register
- PCSrc  out  1  select branch/jump target for the PC
- Stalled  out  1  any Ld deasserted this cycle
- Timeout  out  1  sticky: memory wait exceeded WAIT_MAX
- StallCount  out  CNT_W  saturating count of stalled cycles

Behaviour:
- Clock and reset: one clock, Clk. Reset Rst is asynchronous and active-high.
- While Rst is asserted: state=RUN, all Ld=0, all Flush=1, PCSrc=0, Stalled=0, Timeout=0, StallCount=0, wait counter=0.
- Output timing: outputs are combinational from the registered state and the current inputs, giving zero-latency hazard response. State and counters update on posedge Clk.
- Defaults: all Ld=1, Flush=0, PCSrc=0.
- Taken branch: taken = (MEM_Branch & MEM_Zero) | MEM_Jump.
- MemOp: MEM_MemRead | MEM_MemWrite.
- LoadUse: EX_MemRead & EX_WriteReg!=0 & (EX_WriteReg==ID_Rs | (ID_UsesRt & EX_WriteReg==ID_Rt)).
- State RUN, rules evaluated in priority order:
  - (1) MemOp & !DMem_Ready: all Ld=0, no flush; next state MEM_WAIT, wait counter=1.
  - (2) Taken branch: PCSrc=1, IF_ID_Flush=ID_EX_Flush=EX_MEM_Flush=1, all Ld=1; next state RUN. A simultaneous load-use is discarded because that instruction is wrong-path.
  - (3) LoadUse: PC_Ld=0, IF_ID_Ld=0, ID_EX_Flush=1 (bubble); exactly one stall cycle, then the hazard clears naturally.
- State MEM_WAIT:
  - All Ld=0 while DMem_Ready=0; wait counter increments, saturating at WAIT_MAX.
  - When the counter reaches WAIT_MAX, Timeout sets and stays set until Rst. The pipeline keeps waiting.
  - DMem_Ready=1: apply RUN rules (2)/(3) in the same cycle with all Ld=1, next state RUN, wait counter cleared.
- Stalled: 1 whenever any Ld=0 outside reset.
- StallCount: increments on each Stalled cycle, saturating at all-ones with no wrap.
- Reset mid-wait: immediate return to RUN. The pending memory access is abandoned; the memory side is also reset.
- Rst has priority over all events.

Optional Feature:
- Macro FORWARDING_EN.
- Defined: the datapath has forwarding units; only the load-use rule stalls.
- Undefined: no forwarding. Rule (3) additionally stalls, identically to load-use, on either condition below (each term also requires the destination register !=0):
  - EX_RegWrite and EX_WriteReg matching ID_Rs, or matching ID_Rt when ID_UsesRt.
  - MEM_RegWrite and MEM_WriteReg matching ID_Rs, or matching ID_Rt when ID_UsesRt.
- The register file writes in the first half-cycle, so WB is not checked.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - state enum {RUN, MEM_WAIT}
  - constant REG_ZERO=5'd0
  - a hazard_match function (dest, src, uses).
- One natural sub-module, sat_counter (parameterised width and limit, increment/clear), instanced for the wait counter and for StallCount.

Test Plan:
- Load-use: EX_MemRead=1, EX_WriteReg=8, ID_Rs=8 → one cycle with PC_Ld=0, IF_ID_Ld=0, ID_EX_Flush=1, StallCount=1; next cycle all Ld=1.
- Taken beq: MEM_Branch=1, MEM_Zero=1 while LoadUse is also true → PCSrc=1, three Flush=1, PC_Ld=1, no stall counted.
- Memory wait: MemOp with DMem_Ready low for 3 cycles → all Ld=0 for 3 cycles, StallCount=3, RUN on the ready cycle.
- Timeout: WAIT_MAX=4, DMem_Ready held low for 6 cycles → Timeout=1 after the 4th, stays 1 after ready; cleared only by Rst.
- Rst asserted asynchronously mid-MEM_WAIT → outputs at reset values before the next edge; RUN after release.
- Without FORWARDING_EN: EX_RegWrite=1, EX_WriteReg=9, ID_Rt=9, ID_UsesRt=1 → stall. With FORWARDING_EN → no stall. ID_Rs=0 with EX_WriteReg=0 → no stall in either build.
